// File: rtl/i2s_codec_if_if.sv
// Audio-side bundle of the I2S codec interface: producer handshake plus the
// serial pins toward the board codec. The master modport is the view of the
// i2s_codec_if block itself; the slave modport is the producer/codec side.
interface i2s_codec_if_if #(
    parameter int DATA_BITS = 16
);
    logic                 sample_req;
    logic                 sample_end;
    logic [DATA_BITS-1:0] audio_output;
    logic [DATA_BITS-1:0] audio_input;
    logic                 AUD_BCLK;
    logic                 AUD_DACLRCK;
    logic                 AUD_ADCLRCK;
    logic                 AUD_DACDAT;
    logic                 AUD_ADCDAT;

    modport master (
        output sample_req,
        output sample_end,
        output audio_input,
        output AUD_BCLK,
        output AUD_DACLRCK,
        output AUD_ADCLRCK,
        output AUD_DACDAT,
        input  audio_output,
        input  AUD_ADCDAT
    );

    modport slave (
        input  sample_req,
        input  sample_end,
        input  audio_input,
        input  AUD_BCLK,
        input  AUD_DACLRCK,
        input  AUD_ADCLRCK,
        input  AUD_DACDAT,
        output audio_output,
        output AUD_ADCDAT
    );
endinterface

// File: rtl/i2s_codec_if.sv
// I2S master serializer/deserializer between the sample producer and the
// board codec. BCLK and LRCK are derived from audio_clk; one DAC sample is
// latched per frame (start of left slot) and sent MSB-first on both slots
// with the standard one-BCLK delay after each LRCK edge.
// Optional feature macro: I2S_ADC_EN -- when defined, the left-slot ADC word
// is captured into audio_input and flagged by sample_end; when undefined the
// ADC path is absent, audio_input reads 0 and sample_end stays low.
module i2s_codec_if #(
    parameter int HALF_DIV  = 2,
    parameter int SLOT_BITS = 32,
    parameter int DATA_BITS = 16
) (
    input  logic         audio_clk,
    input  logic         reset,
    i2s_codec_if_if.master bus
);

    localparam int DIV_W = (HALF_DIV > 1) ? $clog2(HALF_DIV) : 1;
    localparam int BIT_W = $clog2(SLOT_BITS);

    logic [DIV_W-1:0]     div_cnt_r;
    logic                 bclk_r;
    logic [BIT_W-1:0]     bit_cnt_r;
    logic                 lrck_r;
    logic [DATA_BITS-1:0] dac_word_r;
    logic [DATA_BITS-1:0] dac_shift_r;
    logic                 dacdat_r;
    logic                 sample_req_r;

    logic                 div_wrap_s;
    logic                 rise_s;
    logic                 fall_s;
    logic                 slot_wrap_s;
    logic [BIT_W-1:0]     bit_next_s;

    // Decode BCLK edge events and the next bit position within the slot.
    always_comb begin
        div_wrap_s  = (div_cnt_r == DIV_W'(HALF_DIV - 1));
        rise_s      = div_wrap_s & ~bclk_r;
        fall_s      = div_wrap_s & bclk_r;
        slot_wrap_s = (bit_cnt_r == BIT_W'(SLOT_BITS - 1));
        if (slot_wrap_s) begin
            bit_next_s = {BIT_W{1'b0}};
        end else begin
            bit_next_s = bit_cnt_r + BIT_W'(1);
        end
    end

    // Divide audio_clk down to BCLK; BCLK toggles each time div_cnt wraps.
    always_ff @(posedge audio_clk or posedge reset) begin
        if (reset) begin
            div_cnt_r <= {DIV_W{1'b0}};
            bclk_r    <= 1'b0;
        end else if (div_wrap_s) begin
            div_cnt_r <= {DIV_W{1'b0}};
            bclk_r    <= ~bclk_r;
        end else begin
            div_cnt_r <= div_cnt_r + DIV_W'(1);
        end
    end

    // Count BCLK falls within a slot; LRCK flips when the slot wraps.
    always_ff @(posedge audio_clk or posedge reset) begin
        if (reset) begin
            bit_cnt_r <= {BIT_W{1'b0}};
            lrck_r    <= 1'b0;
        end else if (fall_s) begin
            bit_cnt_r <= bit_next_s;
            if (slot_wrap_s) begin
                lrck_r <= ~lrck_r;
            end
        end
    end

    // Latch the DAC word at the start of each left slot, reload the shifter
    // at every slot start, and drive DACDAT on falls for bits 1..DATA_BITS.
    always_ff @(posedge audio_clk or posedge reset) begin
        if (reset) begin
            dac_word_r   <= {DATA_BITS{1'b0}};
            dac_shift_r  <= {DATA_BITS{1'b0}};
            dacdat_r     <= 1'b0;
            sample_req_r <= 1'b0;
        end else begin
            sample_req_r <= fall_s & slot_wrap_s & lrck_r;
            if (fall_s) begin
                if (slot_wrap_s) begin
                    dacdat_r <= 1'b0;
                    if (lrck_r) begin
                        dac_word_r  <= bus.audio_output;
                        dac_shift_r <= bus.audio_output;
                    end else begin
                        dac_shift_r <= dac_word_r;
                    end
                end else if (bit_next_s <= BIT_W'(DATA_BITS)) begin
                    dacdat_r    <= dac_shift_r[DATA_BITS-1];
                    dac_shift_r <= {dac_shift_r[DATA_BITS-2:0], 1'b0};
                end else begin
                    dacdat_r <= 1'b0;
                end
            end
        end
    end

    assign bus.AUD_BCLK    = bclk_r;
    assign bus.AUD_DACLRCK = lrck_r;
    assign bus.AUD_ADCLRCK = lrck_r;
    assign bus.AUD_DACDAT  = dacdat_r;
    assign bus.sample_req  = sample_req_r;

`ifdef I2S_ADC_EN
    logic [DATA_BITS-2:0] adc_shift_r;
    logic [DATA_BITS-1:0] audio_input_r;
    logic                 sample_end_r;
    logic                 adc_bit_s;
    logic                 adc_last_s;
    logic [DATA_BITS-1:0] adc_word_s;

    // Qualify left-slot data bits 1..DATA_BITS and form the word-in-progress.
    always_comb begin
        adc_word_s = {adc_shift_r, bus.AUD_ADCDAT};
        if (!lrck_r && (bit_cnt_r != {BIT_W{1'b0}}) &&
            (bit_cnt_r <= BIT_W'(DATA_BITS))) begin
            adc_bit_s  = 1'b1;
            adc_last_s = (bit_cnt_r == BIT_W'(DATA_BITS));
        end else begin
            adc_bit_s  = 1'b0;
            adc_last_s = 1'b0;
        end
    end

    // Shift ADC bits on BCLK rises; publish the word on the last data bit.
    always_ff @(posedge audio_clk or posedge reset) begin
        if (reset) begin
            adc_shift_r   <= {(DATA_BITS-1){1'b0}};
            audio_input_r <= {DATA_BITS{1'b0}};
            sample_end_r  <= 1'b0;
        end else begin
            sample_end_r <= 1'b0;
            if (rise_s && adc_bit_s) begin
                adc_shift_r <= adc_word_s[DATA_BITS-2:0];
                if (adc_last_s) begin
                    audio_input_r <= adc_word_s;
                    sample_end_r  <= 1'b1;
                end
            end
        end
    end

    assign bus.audio_input = audio_input_r;
    assign bus.sample_end  = sample_end_r;
`else
    logic unused_adcdat_s;

    assign unused_adcdat_s = bus.AUD_ADCDAT;
    assign bus.audio_input = {DATA_BITS{1'b0}};
    assign bus.sample_end  = 1'b0;
`endif

endmodule

// File: tb/tb_i2s_codec_if.sv
// Self-checking bench for i2s_codec_if. A frame-position reference model
// (cycles since reset -> BCLK, slot, bit index, latched word) predicts every
// output; scenario tasks compare the DUT against it.
module tb_i2s_codec_if;

    localparam int HALF  = 2;
    localparam int SLOT  = 32;
    localparam int DW    = 16;
    localparam int BPER  = 2 * HALF;
    localparam int FRAME = BPER * 2 * SLOT;

    logic audio_clk = 1'b0;
    logic reset     = 1'b0;

    i2s_codec_if_if #(.DATA_BITS(DW)) bus_if ();

    i2s_codec_if #(
        .HALF_DIV (HALF),
        .SLOT_BITS(SLOT),
        .DATA_BITS(DW)
    ) dut (
        .audio_clk(audio_clk),
        .reset    (reset),
        .bus      (bus_if)
    );

    always #5 audio_clk = ~audio_clk;

    int n_pass  = 0;
    int n_total = 0;

    // reference model state
    int            t;
    int            b_pos;
    int            l_pos;
    logic [DW-1:0] frame_word;
    logic [DW-1:0] cap_word;
    logic [DW-1:0] exp_ain;
    logic [DW-1:0] adc_left;
    logic [DW-1:0] adc_right;
    logic          exp_bclk;
    logic          exp_lrck;
    logic          exp_req;
    logic          exp_dac;
    logic          exp_end;

    task automatic model_reset();
        t          = 0;
        b_pos      = 0;
        l_pos      = 0;
        frame_word = 16'h0000;
        cap_word   = 16'h0000;
        exp_ain    = 16'h0000;
        exp_bclk   = 1'b0;
        exp_lrck   = 1'b0;
        exp_req    = 1'b0;
        exp_dac    = 1'b0;
        exp_end    = 1'b0;
    endtask

    // One audio_clk edge; update predictions, then drive the codec ADC bit.
    task automatic advance();
        logic [DW-1:0] aout_edge;
        logic          adc_edge;
        int            k;
        int            rb;
        int            rl;
        aout_edge = bus_if.audio_output;
        adc_edge  = bus_if.AUD_ADCDAT;
        @(posedge audio_clk);
        #1;
        t++;
        exp_bclk = ((t / HALF) % 2) == 1;
        b_pos    = (t / BPER) % SLOT;
        l_pos    = (t / (BPER * SLOT)) % 2;
        exp_lrck = (l_pos == 1);
        exp_req  = (t % FRAME) == 0;
        if (exp_req) frame_word = aout_edge;
        exp_dac  = (b_pos >= 1 && b_pos <= DW) ? frame_word[DW-b_pos] : 1'b0;
        exp_end  = 1'b0;
        if ((t % BPER) == HALF) begin
            k  = t / BPER;
            rb = k % SLOT;
            rl = (k / SLOT) % 2;
            if (rl == 0 && rb >= 1 && rb <= DW) begin
                cap_word[DW-rb] = adc_edge;
`ifdef I2S_ADC_EN
                if (rb == DW) begin
                    exp_end = 1'b1;
                    exp_ain = cap_word;
                end
`endif
            end
        end
        if (b_pos >= 1 && b_pos <= DW)
            bus_if.AUD_ADCDAT = (l_pos == 0) ? adc_left[DW-b_pos] : adc_right[DW-b_pos];
        else
            bus_if.AUD_ADCDAT = 1'($urandom);
    endtask

    // Advance at least once, stopping on the next frame-load edge.
    task automatic to_load();
        advance();
        for (int i = 0; i < FRAME && (t % FRAME) != 0; i++) advance();
    endtask

    task automatic test_reset();
        bus_if.audio_output = 16'h0000;
        bus_if.AUD_ADCDAT   = 1'b0;
        adc_left  = 16'h0000;
        adc_right = 16'h0000;
        #2 reset = 1'b1;
        #1;
        n_total++; if (bus_if.sample_req !== 1'b0) $display("FAIL rst_req got %b want 0", bus_if.sample_req); else n_pass++;
        n_total++; if (bus_if.sample_end !== 1'b0) $display("FAIL rst_end got %b want 0", bus_if.sample_end); else n_pass++;
        n_total++; if (bus_if.audio_input !== 16'h0000) $display("FAIL rst_ain got %h want 0000", bus_if.audio_input); else n_pass++;
        n_total++; if (bus_if.AUD_BCLK !== 1'b0) $display("FAIL rst_bclk got %b want 0", bus_if.AUD_BCLK); else n_pass++;
        n_total++; if (bus_if.AUD_DACLRCK !== 1'b0) $display("FAIL rst_daclrck got %b want 0", bus_if.AUD_DACLRCK); else n_pass++;
        n_total++; if (bus_if.AUD_ADCLRCK !== 1'b0) $display("FAIL rst_adclrck got %b want 0", bus_if.AUD_ADCLRCK); else n_pass++;
        n_total++; if (bus_if.AUD_DACDAT !== 1'b0) $display("FAIL rst_dacdat got %b want 0", bus_if.AUD_DACDAT); else n_pass++;
        @(posedge audio_clk);
        @(posedge audio_clk);
        #1 reset = 1'b0;
        model_reset();
        // first frame carries zero data; first request lands on edge FRAME
        for (int i = 0; i < FRAME; i++) begin
            advance();
            n_total++; if (bus_if.AUD_DACDAT !== exp_dac) $display("FAIL first_frame_dac t=%0d got %b want %b", t, bus_if.AUD_DACDAT, exp_dac); else n_pass++;
            n_total++; if (bus_if.sample_req !== exp_req) $display("FAIL first_frame_req t=%0d got %b want %b", t, bus_if.sample_req, exp_req); else n_pass++;
            n_total++; if (bus_if.AUD_BCLK !== exp_bclk) $display("FAIL first_frame_bclk t=%0d got %b want %b", t, bus_if.AUD_BCLK, exp_bclk); else n_pass++;
        end
    endtask

    task automatic test_dac_pattern();
        logic [DW-1:0] got_l;
        logic [DW-1:0] got_r;
        got_l = 16'h0000;
        got_r = 16'h0000;
        bus_if.audio_output = 16'hA5C3;
        to_load();
        for (int i = 0; i < FRAME; i++) begin
            advance();
            n_total++; if (bus_if.AUD_DACDAT !== exp_dac) $display("FAIL a5c3_dac t=%0d bit=%0d got %b want %b", t, b_pos, bus_if.AUD_DACDAT, exp_dac); else n_pass++;
            if ((t % BPER) == 0 && b_pos >= 1 && b_pos <= DW) begin
                if (l_pos == 0) got_l[DW-b_pos] = bus_if.AUD_DACDAT;
                else            got_r[DW-b_pos] = bus_if.AUD_DACDAT;
            end
        end
        n_total++; if (got_l !== 16'hA5C3) $display("FAIL a5c3_left got %h want a5c3", got_l); else n_pass++;
        n_total++; if (got_r !== 16'hA5C3) $display("FAIL a5c3_right got %h want a5c3", got_r); else n_pass++;
    endtask

    task automatic test_free_run();
        int   last_req  = -1;
        int   last_rise = -1;
        int   nreq      = 0;
        logic prev_bclk;
        logic prev_lrck;
        prev_bclk = bus_if.AUD_BCLK;
        prev_lrck = bus_if.AUD_DACLRCK;
        for (int i = 0; i < 4 * FRAME; i++) begin
            bus_if.audio_output = 16'($urandom);
            advance();
            n_total++; if (bus_if.AUD_BCLK !== exp_bclk) $display("FAIL run_bclk t=%0d got %b want %b", t, bus_if.AUD_BCLK, exp_bclk); else n_pass++;
            n_total++; if (bus_if.AUD_DACLRCK !== exp_lrck) $display("FAIL run_lrck t=%0d got %b want %b", t, bus_if.AUD_DACLRCK, exp_lrck); else n_pass++;
            n_total++; if (bus_if.AUD_ADCLRCK !== bus_if.AUD_DACLRCK) $display("FAIL run_adclrck t=%0d got %b want %b", t, bus_if.AUD_ADCLRCK, bus_if.AUD_DACLRCK); else n_pass++;
            n_total++; if (bus_if.sample_req !== exp_req) $display("FAIL run_req t=%0d got %b want %b", t, bus_if.sample_req, exp_req); else n_pass++;
            n_total++; if (bus_if.AUD_DACDAT !== exp_dac) $display("FAIL run_dac t=%0d got %b want %b", t, bus_if.AUD_DACDAT, exp_dac); else n_pass++;
            if (bus_if.sample_req === 1'b1) begin
                n_total++; if (!(prev_lrck === 1'b1 && bus_if.AUD_DACLRCK === 1'b0)) $display("FAIL req_lrck_edge t=%0d got %b->%b want 1->0", t, prev_lrck, bus_if.AUD_DACLRCK); else n_pass++;
                if (last_req >= 0) begin
                    n_total++; if (t - last_req != FRAME) $display("FAIL req_spacing t=%0d got %0d want %0d", t, t - last_req, FRAME); else n_pass++;
                end
                last_req = t;
                nreq++;
            end
            if (prev_bclk === 1'b0 && bus_if.AUD_BCLK === 1'b1) begin
                if (last_rise >= 0) begin
                    n_total++; if (t - last_rise != BPER) $display("FAIL bclk_period t=%0d got %0d want %0d", t, t - last_rise, BPER); else n_pass++;
                end
                last_rise = t;
            end
            prev_bclk = bus_if.AUD_BCLK;
            prev_lrck = bus_if.AUD_DACLRCK;
        end
        n_total++; if (nreq != 4) $display("FAIL req_count got %0d want 4", nreq); else n_pass++;
    endtask

    task automatic test_late_change();
        logic [DW-1:0] want [2];
        logic [DW-1:0] got_l;
        logic [DW-1:0] got_r;
        want[0] = 16'h1234;
        want[1] = 16'hFFFF;
        for (int i = 0; i < FRAME && (t % FRAME) != FRAME - 1; i++) advance();
        bus_if.audio_output = 16'h1234;
        advance();
        n_total++; if (bus_if.sample_req !== 1'b1) $display("FAIL late_load_req t=%0d got %b want 1", t, bus_if.sample_req); else n_pass++;
        for (int fi = 0; fi < 2; fi++) begin
            got_l = 16'h0000;
            got_r = 16'h0000;
            for (int i = 0; i < FRAME; i++) begin
                advance();
                if (fi == 0 && i == 9) bus_if.audio_output = 16'hFFFF;
                n_total++; if (bus_if.AUD_DACDAT !== exp_dac) $display("FAIL late_dac t=%0d got %b want %b", t, bus_if.AUD_DACDAT, exp_dac); else n_pass++;
                if ((t % BPER) == 0 && b_pos >= 1 && b_pos <= DW) begin
                    if (l_pos == 0) got_l[DW-b_pos] = bus_if.AUD_DACDAT;
                    else            got_r[DW-b_pos] = bus_if.AUD_DACDAT;
                end
            end
            n_total++; if (got_l !== want[fi]) $display("FAIL late_left frame=%0d got %h want %h", fi, got_l, want[fi]); else n_pass++;
            n_total++; if (got_r !== want[fi]) $display("FAIL late_right frame=%0d got %h want %h", fi, got_r, want[fi]); else n_pass++;
        end
    endtask

    task automatic test_adc();
        logic [DW-1:0] wl;
        int            ends;
        for (int rep = 0; rep < 2; rep++) begin
            wl   = (rep == 0) ? 16'h8001 : 16'($urandom);
            ends = 0;
            to_load();
            adc_left  = wl;
            adc_right = (rep == 0) ? 16'hFFFF : 16'($urandom);
            for (int i = 0; i < FRAME; i++) begin
                advance();
                n_total++; if (bus_if.sample_end !== exp_end) $display("FAIL adc_end t=%0d got %b want %b", t, bus_if.sample_end, exp_end); else n_pass++;
                n_total++; if (bus_if.audio_input !== exp_ain) $display("FAIL adc_word t=%0d got %h want %h", t, bus_if.audio_input, exp_ain); else n_pass++;
                n_total++; if (bus_if.sample_end === 1'b1 && bus_if.sample_req === 1'b1) $display("FAIL end_req_overlap t=%0d got 1/1 want not both", t); else n_pass++;
                if (bus_if.sample_end === 1'b1) ends++;
            end
`ifdef I2S_ADC_EN
            n_total++; if (bus_if.audio_input !== wl) $display("FAIL adc_final got %h want %h", bus_if.audio_input, wl); else n_pass++;
            n_total++; if (ends != 1) $display("FAIL adc_end_count got %0d want 1", ends); else n_pass++;
`else
            n_total++; if (bus_if.audio_input !== 16'h0000) $display("FAIL adc_final got %h want 0000", bus_if.audio_input); else n_pass++;
            n_total++; if (ends != 0) $display("FAIL adc_end_count got %0d want 0", ends); else n_pass++;
`endif
        end
    endtask

    task automatic test_reset_mid_frame();
        int n     = 0;
        int found = 0;
        bus_if.audio_output = 16'h5A5A;
        for (int i = 0; i < FRAME && (t % FRAME) != 200; i++) advance();
        #2 reset = 1'b1;
        #1;
        n_total++; if (bus_if.sample_req !== 1'b0) $display("FAIL mid_rst_req got %b want 0", bus_if.sample_req); else n_pass++;
        n_total++; if (bus_if.sample_end !== 1'b0) $display("FAIL mid_rst_end got %b want 0", bus_if.sample_end); else n_pass++;
        n_total++; if (bus_if.audio_input !== 16'h0000) $display("FAIL mid_rst_ain got %h want 0000", bus_if.audio_input); else n_pass++;
        n_total++; if (bus_if.AUD_BCLK !== 1'b0) $display("FAIL mid_rst_bclk got %b want 0", bus_if.AUD_BCLK); else n_pass++;
        n_total++; if (bus_if.AUD_DACLRCK !== 1'b0) $display("FAIL mid_rst_daclrck got %b want 0", bus_if.AUD_DACLRCK); else n_pass++;
        n_total++; if (bus_if.AUD_ADCLRCK !== 1'b0) $display("FAIL mid_rst_adclrck got %b want 0", bus_if.AUD_ADCLRCK); else n_pass++;
        n_total++; if (bus_if.AUD_DACDAT !== 1'b0) $display("FAIL mid_rst_dacdat got %b want 0", bus_if.AUD_DACDAT); else n_pass++;
        @(posedge audio_clk);
        @(posedge audio_clk);
        #1 reset = 1'b0;
        model_reset();
        for (int i = 0; i < 2 * FRAME && found == 0; i++) begin
            advance();
            n++;
            n_total++; if (bus_if.AUD_DACDAT !== exp_dac) $display("FAIL mid_rst_zero_frame t=%0d got %b want %b", t, bus_if.AUD_DACDAT, exp_dac); else n_pass++;
            if (bus_if.sample_req === 1'b1) found = 1;
        end
        n_total++; if (found == 0 || n != FRAME) $display("FAIL mid_rst_first_req got %0d cycles (seen=%0d) want %0d", n, found, FRAME); else n_pass++;
    endtask

    initial begin
        model_reset();
        test_reset();
        test_dac_pattern();
        test_free_run();
        test_late_change();
        test_adc();
        test_reset_mid_frame();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
